// File: rtl/serial_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : serial_bus_master
// Brief    : Parallel-request to MSB-first serial bus master. Pauses and
//            resumes on grant loss, reads back serial data and can time out
//            a silent slave when MASTER_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module serial_bus_master #(
    parameter int ADDR_WIDTH     = 14,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  bus_ready,
    input  logic                  slave_ready,
    input  logic                  slave_valid,
    input  logic                  data_rx,
    output logic                  bus_req,
    output logic                  valid,
    output logic                  addr_tx,
    output logic                  data_tx,
    output logic                  valid_s,
    output logic                  write_en_slave,
    output logic                  master_busy,
    output logic [DATA_WIDTH-1:0] data_read,
    output logic                  done,
    output logic                  error
);

    localparam int               CNT_W      = $clog2(ADDR_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_START = CNT_W'(ADDR_WIDTH - DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_SHIFT = 3'd2,
        S_WAIT  = 3'd3,
        S_RX    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                state, state_n;
    logic                  en_prev;
    logic                  start;
    logic [ADDR_WIDTH-1:0] addr_sh, addr_sh_n;
    logic [DATA_WIDTH-1:0] data_sh, data_sh_n;
    logic                  is_read, is_read_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [DATA_WIDTH-1:0] rx_buf, rx_buf_n;
    logic                  timeout_hit;

    logic                  bus_req_n, valid_n, addr_tx_n, data_tx_n, valid_s_n;
    logic                  write_en_slave_n, master_busy_n, done_n, error_n;
    logic [DATA_WIDTH-1:0] data_read_n;

    // Slave availability is advisory only; the frame never waits on it.
    logic unused_slave_ready;
    assign unused_slave_ready = slave_ready;

    assign start = enable && !en_prev && (state == S_IDLE);

`ifdef MASTER_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;

    // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
    always_ff @(posedge clock) begin
        if (reset || state != S_WAIT) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == S_WAIT) && (to_cnt == TO_LAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_n          = state;
        addr_sh_n        = addr_sh;
        data_sh_n        = data_sh;
        is_read_n        = is_read;
        cnt_n            = cnt;
        rx_buf_n         = rx_buf;
        bus_req_n        = bus_req;
        valid_n          = valid;
        addr_tx_n        = addr_tx;
        data_tx_n        = data_tx;
        valid_s_n        = 1'b0;
        write_en_slave_n = write_en_slave;
        master_busy_n    = master_busy;
        data_read_n      = data_read;
        done_n           = 1'b0;
        error_n          = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    addr_sh_n        = addr_in;
                    data_sh_n        = data_in;
                    is_read_n        = read_en;
                    bus_req_n        = 1'b1;
                    valid_n          = 1'b1;
                    master_busy_n    = 1'b1;
                    write_en_slave_n = ~read_en;
                    state_n          = S_REQ;
                end
            end

            S_REQ: begin
                if (bus_ready) begin
                    valid_n = 1'b0;
                    cnt_n   = '0;
                    state_n = S_SHIFT;
                end
            end

            S_SHIFT: begin
                // Without a grant nothing moves: serial lines and counter hold.
                if (bus_ready) begin
                    valid_s_n = 1'b1;
                    addr_tx_n = addr_sh[ADDR_WIDTH-1];
                    addr_sh_n = addr_sh << 1;
                    if (!is_read && cnt >= DATA_START) begin
                        data_tx_n = data_sh[DATA_WIDTH-1];
                        data_sh_n = data_sh << 1;
                    end else begin
                        data_tx_n = 1'b0;
                    end
                    cnt_n = cnt + 1'b1;
                    if (cnt == LAST_BEAT) begin
                        if (is_read) begin
                            state_n = S_WAIT;
                        end else begin
                            done_n        = 1'b1;
                            bus_req_n     = 1'b0;
                            master_busy_n = 1'b0;
                            state_n       = S_DONE;
                        end
                    end
                end
            end

            S_WAIT: begin
                addr_tx_n = 1'b0;
                data_tx_n = 1'b0;
                if (slave_valid) begin
                    cnt_n   = '0;
                    state_n = S_RX;
                end else if (timeout_hit) begin
                    done_n        = 1'b1;
                    error_n       = 1'b1;
                    bus_req_n     = 1'b0;
                    master_busy_n = 1'b0;
                    state_n       = S_DONE;
                end
            end

            S_RX: begin
                rx_buf_n = (rx_buf << 1) | DATA_WIDTH'(data_rx);
                cnt_n    = cnt + 1'b1;
                if (cnt == LAST_BIT) begin
                    data_read_n   = rx_buf_n;
                    done_n        = 1'b1;
                    bus_req_n     = 1'b0;
                    master_busy_n = 1'b0;
                    state_n       = S_DONE;
                end
            end

            S_DONE: begin
                addr_tx_n = 1'b0;
                data_tx_n = 1'b0;
                state_n   = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            en_prev        <= 1'b0;
            addr_sh        <= '0;
            data_sh        <= '0;
            is_read        <= 1'b0;
            cnt            <= '0;
            rx_buf         <= '0;
            bus_req        <= 1'b0;
            valid          <= 1'b0;
            addr_tx        <= 1'b0;
            data_tx        <= 1'b0;
            valid_s        <= 1'b0;
            write_en_slave <= 1'b0;
            master_busy    <= 1'b0;
            data_read      <= '0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            state          <= state_n;
            en_prev        <= enable;
            addr_sh        <= addr_sh_n;
            data_sh        <= data_sh_n;
            is_read        <= is_read_n;
            cnt            <= cnt_n;
            rx_buf         <= rx_buf_n;
            bus_req        <= bus_req_n;
            valid          <= valid_n;
            addr_tx        <= addr_tx_n;
            data_tx        <= data_tx_n;
            valid_s        <= valid_s_n;
            write_en_slave <= write_en_slave_n;
            master_busy    <= master_busy_n;
            data_read      <= data_read_n;
            done           <= done_n;
            error          <= error_n;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_bus_master
// Brief    : Randomized scoreboard bench for serial_bus_master; honours
//            MASTER_TIMEOUT_EN for the timeout scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_bus_master;

    localparam int A  = 14;
    localparam int D  = 8;
    localparam int TO = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable, read_en, bus_ready, slave_ready, slave_valid, data_rx;
    logic [A-1:0] addr_in;
    logic [D-1:0] data_in;
    logic         bus_req, valid, addr_tx, data_tx, valid_s, write_en_slave, master_busy;
    logic [D-1:0] data_read;
    logic         done, error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [A-1:0] addr;
        logic [A-1:0] dstream;
        logic         rd;
        logic         err;
        logic [D-1:0] rdata;
        int           done_cyc;
    } exp_t;

    exp_t         sb[$];
    int           start_q[$];
    logic [D-1:0] model_rd = '0;

    serial_bus_master #(
        .ADDR_WIDTH    (A),
        .DATA_WIDTH    (D),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .read_en       (read_en),
        .addr_in       (addr_in),
        .data_in       (data_in),
        .bus_ready     (bus_ready),
        .slave_ready   (slave_ready),
        .slave_valid   (slave_valid),
        .data_rx       (data_rx),
        .bus_req       (bus_req),
        .valid         (valid),
        .addr_tx       (addr_tx),
        .data_tx       (data_tx),
        .valid_s       (valid_s),
        .write_en_slave(write_en_slave),
        .master_busy   (master_busy),
        .data_read     (data_read),
        .done          (done),
        .error         (error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({bus_req, valid, addr_tx, data_tx, valid_s, write_en_slave,
                    master_busy, done, error, data_read});
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rand_misc();
        bus_ready   = 1'($urandom);
        slave_ready = 1'($urandom);
        slave_valid = 1'($urandom);
        data_rx     = 1'($urandom);
        read_en     = 1'($urandom);
        addr_in     = A'($urandom);
        data_in     = D'($urandom);
    endtask

    task automatic idle_gap(input int n);
        for (int g = 0; g < n; g++) begin
            rand_misc();
            enable = 1'b0;
            step();
        end
    endtask

    // mode 0: random grant gaps, 1: grant always high, 2: three-cycle gap after beat 4
    task automatic run_xfer(input bit rd, input logic [A-1:0] a, input logic [D-1:0] d,
                            input logic [D-1:0] rxw, input int k, input int mode,
                            input bit to_exp);
        bit   br[$];
        int   r, p, beats, w0, sv_c, done_c;
        exp_t e;
        r = (mode == 0) ? int'($urandom_range(0, 2)) : 0;
        for (int i = 0; i < r; i++) br.push_back(1'b0);
        br.push_back(1'b1);
        p     = 0;
        beats = 0;
        while (beats < A) begin
            if ((mode == 0 && $urandom_range(0, 3) == 0) || (mode == 2 && beats == 5 && p < 3)) begin
                br.push_back(1'b0);
                p++;
            end else begin
                br.push_back(1'b1);
                beats++;
            end
        end
        w0   = r + A + p + 2;
        sv_c = w0 + k;
        if (!rd)        done_c = w0;
        else if (to_exp) done_c = w0 + TO;
        else            done_c = sv_c + D + 1;

        e.addr     = a;
        e.dstream  = rd ? '0 : A'(d);
        e.rd       = rd;
        e.err      = to_exp;
        e.rdata    = (rd && !to_exp) ? rxw : model_rd;
        e.done_cyc = cyc + done_c;
        if (rd && !to_exp) model_rd = rxw;
        sb.push_back(e);
        start_q.push_back(cyc);

        for (int c = 0; c <= done_c; c++) begin
            rand_misc();
            enable = (c == 0) ? 1'b1 : 1'($urandom);
            if (c == 0) begin
                read_en = rd;
                addr_in = a;
                data_in = d;
            end
            if (c >= 1 && c <= br.size()) bus_ready = br[c-1];
            if (rd && c >= w0 && (to_exp ? (c < done_c) : (c < sv_c))) slave_valid = 1'b0;
            else if (rd && !to_exp && c == sv_c) slave_valid = 1'b1;
            if (rd && !to_exp && c > sv_c && c <= sv_c + D) data_rx = rxw[D-1-(c-sv_c-1)];
            step();
        end
        idle_gap(int'($urandom_range(1, 3)));
    endtask

    task automatic abort_xfer(input logic [A-1:0] a, input logic [D-1:0] d);
        for (int c = 0; c <= 9; c++) begin
            rand_misc();
            enable    = (c == 0);
            read_en   = 1'b0;
            addr_in   = a;
            data_in   = d;
            bus_ready = 1'b1;
            reset     = (c == 9);
            step();
        end
        chk("reset_abort_outputs", out_vec(), 64'd0);
        reset    = 1'b0;
        model_rd = '0;
        idle_gap(3);
    endtask

    // Monitor: rebuilds the serial stream from beats and scores each completion.
    logic [A-1:0] addr_col = '0;
    logic [A-1:0] data_col = '0;
    int           nbeats   = 0;
    logic [D-1:0] prev_dr  = '0;
    logic         rst_seen = 1'b1;

    always @(negedge clock) begin
        exp_t e;
        if (valid_s === 1'b1) begin
            addr_col = (addr_col << 1) | A'(addr_tx);
            data_col = (data_col << 1) | A'(data_tx);
            nbeats++;
        end
        if (!rst_seen && done !== 1'b1 && data_read !== prev_dr) begin
            total++;
            bad++;
            $display("FAIL data_read_stable: got %0h expected %0h (cycle %0d)", data_read, prev_dr, cyc);
        end
        if (start_q.size() > 0 && cyc == start_q[0] + 1) begin
            chk("req_phase_flags", 64'({bus_req, valid, master_busy}), 64'd7);
            void'(start_q.pop_front());
        end
        if (error === 1'b1 && done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL error_without_done: got 1 expected 0 (cycle %0d)", cyc);
        end
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_cycle",     64'(cyc),            64'(e.done_cyc));
                chk("beat_count",     64'(nbeats),         64'(A));
                chk("addr_stream",    64'(addr_col),       64'(e.addr));
                chk("data_stream",    64'(data_col),       64'(e.dstream));
                chk("data_read",      64'(data_read),      64'(e.rdata));
                chk("error",          64'(error),          64'(e.err));
                chk("release_flags",  64'({bus_req, master_busy}), 64'd0);
                chk("write_en_slave", 64'(write_en_slave), 64'(!e.rd));
            end
            addr_col = '0;
            data_col = '0;
            nbeats   = 0;
        end else if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
            total++;
            bad++;
            $display("FAIL done_missing: got 0 expected 1 by cycle %0d", sb[0].done_cyc);
            void'(sb.pop_front());
            addr_col = '0;
            data_col = '0;
            nbeats   = 0;
        end
        if (reset === 1'b1) begin
            addr_col = '0;
            data_col = '0;
            nbeats   = 0;
        end
        prev_dr  = data_read;
        rst_seen = (reset === 1'b1);
    end

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        rand_misc();
        repeat (3) step();
        chk("reset_outputs", out_vec(), 64'd0);
        reset = 1'b0;
        idle_gap(2);

        run_xfer(1'b0, 14'h2A5B, 8'hC3, 8'h00, 0, 1, 1'b0);
        run_xfer(1'b0, 14'h2A5B, 8'hC3, 8'h00, 0, 2, 1'b0);
        run_xfer(1'b1, 14'h0001, 8'h00, 8'h96, 4, 1, 1'b0);
        abort_xfer(14'h1357, 8'hA5);
        run_xfer(1'b0, 14'h3FFF, 8'hFF, 8'h00, 0, 1, 1'b0);
`ifdef MASTER_TIMEOUT_EN
        run_xfer(1'b1, 14'h0ABC, 8'h00, 8'h00, 0, 0, 1'b1);
`endif
        for (int t = 0; t < 24; t++) begin
            bit rd;
            bit to_exp;
            rd     = 1'($urandom);
            to_exp = 1'b0;
`ifdef MASTER_TIMEOUT_EN
            to_exp = rd && ($urandom_range(0, 4) == 0);
`endif
            run_xfer(rd, A'($urandom), D'($urandom), D'($urandom),
                     int'($urandom_range(0, 6)), 0, to_exp);
        end

        idle_gap(5);
        chk("scoreboard_drained", 64'(sb.size() + start_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
